// File: rtl/instr_dispatch.sv
// ---------------------------------------------------------------------------
// instr_dispatch
//
// Buffers instructions {cpu, rw, addr, data} from a producer in a small FIFO.
// It issues them one at a time to a group of processors. Each transaction
// runs until the selected processor pulses done, or until TMO cycles have
// elapsed. After every transaction there is one GAP cycle with no processor
// selected, so the processors return to snoop phase 0.
//
// Handshake: in_valid / in_ready follow strict valid/ready semantics.
//   - A transfer happens on a rising clock edge where both signals are high.
//   - in_ready depends only on registered state (occupancy and the
//     post-reset enable). It never depends on in_valid or on a pop in the
//     same cycle.
//   - Once the producer raises in_valid, it holds the instruction stable
//     until the transfer happens.
//
// Ports
//   clock        sole clock, rising edge
//   resetn       synchronous active-low reset
//   in_valid     producer offers an instruction
//   in_ready     queue can accept (count < DEPTH, low during reset)
//   in_cpu       target processor 0..2 (3 is illegal and is dropped)
//   in_rw        0 = read, 1 = write
//   in_addr      block address
//   in_data      write data
//   execpu       processor selected for execution, 2'b11 = none
//   readwrite    operation presented to the processors
//   address      address presented to the processors
//   data         write data presented to the processors
//   done         completion pulse from the executing processor
//   busy         a transaction is in flight
//   count        queue occupancy, 0..DEPTH
//   err_bad_cpu  one-cycle pulse after an in_cpu == 3 instruction is accepted
//   timeout      one-cycle pulse after a transaction ends without done
//   dbg_state    current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module instr_dispatch #(
   parameter int DEPTH = 4,
   parameter int TMO   = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_cpu,
   input  logic       in_rw,
   input  logic [2:0] in_addr,
   input  logic [2:0] in_data,
   output logic [1:0] execpu,
   output logic       readwrite,
   output logic [2:0] address,
   output logic [2:0] data,
   input  logic       done,
   output logic       busy,
   output logic [3:0] count,
   output logic       err_bad_cpu,
   output logic       timeout,
   output logic [1:0] dbg_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(TMO + 1);
   localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
   localparam logic [PW-1:0] PH_LAST = PW'(TMO - 1);
   localparam logic [1:0]    NO_CPU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [8:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [PW-1:0]  phase;
   logic           ready_en;

   logic           accept;
   logic           push;
   logic           bad_cpu;
   logic           pop;
   logic           tmo_hit;
   logic [8:0]     head;

   // ready_en is cleared by reset. It keeps in_ready low during reset and
   // lets it rise on the first cycle after reset is released.
   assign in_ready  = ready_en && (count < DEPTH_C);
   assign accept    = in_valid && in_ready;
   assign bad_cpu   = accept && (in_cpu == NO_CPU);
   assign push      = accept && (in_cpu != NO_CPU);
   assign head      = mem[rd_ptr];
   assign busy      = (state == S_RUN);
   assign dbg_state = state;

   // Next-state logic. Pop happens only from IDLE with a non-empty queue,
   // so the queue is never popped when empty. A done in RUN takes priority
   // over the timeout condition.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != 4'd0) begin
               pop       = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (done) begin
               state_nxt = S_GAP;
            end else if (phase == PH_LAST) begin
               state_nxt = S_GAP;
               tmo_hit   = 1'b1;
            end
         end
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Queue storage. The contents need no reset because the pointers and
   // count define which entries are valid.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {in_cpu, in_rw, in_addr, in_data};
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= 4'd0;
         ready_en    <= 1'b0;
         err_bad_cpu <= 1'b0;
         timeout     <= 1'b0;
         execpu      <= NO_CPU;
         readwrite   <= 1'b0;
         address     <= 3'd0;
         data        <= 3'd0;
         phase       <= '0;
      end else begin
         ready_en    <= 1'b1;
         err_bad_cpu <= bad_cpu;
         timeout     <= tmo_hit;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase

         // readwrite, address and data are loaded only on issue. They
         // keep their last value while execpu shows no processor.
         if (pop) begin
            execpu    <= head[8:7];
            readwrite <= head[6];
            address   <= head[5:3];
            data      <= head[2:0];
            phase     <= '0;
         end else if (state == S_RUN) begin
            if (state_nxt == S_GAP) execpu <= NO_CPU;
            else                    phase  <= phase + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_dispatch.sv
// ---------------------------------------------------------------------------
// tb_instr_dispatch
//
// Self-checking bench for instr_dispatch with DEPTH = 4 and TMO = 4.
//
// A cycle-by-cycle vector table covers:
//   - reset
//   - a write that completes on its second RUN cycle
//   - a read that times out
//   - a dropped cpu-3 instruction
//   - done coinciding with the last phase
//
// Hand-written sequences cover:
//   - filling the queue while a transaction runs, checked for FIFO issue
//     order through an expected-issue queue
//   - reset in the middle of RUN with entries queued
// ---------------------------------------------------------------------------
module tb_instr_dispatch;

   logic       clock;
   logic       resetn;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_cpu;
   logic       in_rw;
   logic [2:0] in_addr;
   logic [2:0] in_data;
   logic [1:0] execpu;
   logic       readwrite;
   logic [2:0] address;
   logic [2:0] data;
   logic       done;
   logic       busy;
   logic [3:0] count;
   logic       err_bad_cpu;
   logic       timeout;
   logic [1:0] dbg_state;

   instr_dispatch #(.DEPTH(4), .TMO(4)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cpu     (in_cpu),
      .in_rw      (in_rw),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .execpu     (execpu),
      .readwrite  (readwrite),
      .address    (address),
      .data       (data),
      .done       (done),
      .busy       (busy),
      .count      (count),
      .err_bad_cpu(err_bad_cpu),
      .timeout    (timeout),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [8:0]  exp_q[$];
   logic        mon_en = 1'b0;
   logic [1:0]  prev_exec = 2'b11;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every issue is a change of execpu from 3 to a real processor. Each
   // issued {cpu, rw, addr, data} must match the head of the expected queue.
   always @(negedge clock) begin
      if (mon_en && execpu != 2'b11 && prev_exec == 2'b11) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_unexpected: got 0x%0h, expected no issue", {execpu, readwrite, address, data});
         end else begin
            chk("issue_order", {23'd0, execpu, readwrite, address, data}, {23'd0, exp_q.pop_front()});
         end
      end
      prev_exec = execpu;
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        rn;
      logic        v;
      logic [1:0]  cpu;
      logic        rw;
      logic [2:0]  a;
      logic [2:0]  d;
      logic        dn;
      logic [16:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Expected-output layout: {execpu, readwrite, address, data, busy, count, in_ready, err, timeout}
   task automatic add(input logic rn, input logic v, input logic [1:0] cpu, input logic rw,
                      input logic [2:0] a, input logic [2:0] d, input logic dn,
                      input logic [1:0] e_ex, input logic e_rw, input logic [2:0] e_a, input logic [2:0] e_d,
                      input logic e_bsy, input logic [3:0] e_cnt, input logic e_rdy, input logic e_err, input logic e_tmo);
      vec_t t;
      t.rn = rn; t.v = v; t.cpu = cpu; t.rw = rw; t.a = a; t.d = d; t.dn = dn;
      t.exp = {e_ex, e_rw, e_a, e_d, e_bsy, e_cnt, e_rdy, e_err, e_tmo};
      vecs.push_back(t);
   endtask

   function automatic logic [16:0] obs();
      return {execpu, readwrite, address, data, busy, count, in_ready, err_bad_cpu, timeout};
   endfunction

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] cpu, input logic rw, input logic [2:0] a, input logic [2:0] d);
      in_valid = v; in_cpu = cpu; in_rw = rw; in_addr = a; in_data = d;
   endtask

   initial begin
      resetn = 1'b0;
      done   = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 3'd0, 3'd0);

      //   rn v  cpu rw a  d  dn | ex rw a  d  bsy cnt rdy err tmo
      // Reset, then in_ready rises on the first cycle after release.
      add(0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 1, 0, 0);
      // Write {cpu 1, addr 5, data 6}; done on the 2nd RUN cycle.
      add(1, 1, 1, 1, 5, 6, 0,   3, 0, 0, 0, 0, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   1, 1, 5, 6, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   1, 1, 5, 6, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,   3, 1, 5, 6, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   3, 1, 5, 6, 0, 0, 1, 0, 0);
      // Read {cpu 0, addr 2}, no done: 4 RUN cycles, timeout, GAP, IDLE.
      add(1, 1, 0, 0, 2, 0, 0,   3, 1, 5, 6, 0, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   3, 0, 2, 0, 0, 0, 1, 0, 1);
      add(1, 0, 0, 0, 0, 0, 0,   3, 0, 2, 0, 0, 0, 1, 0, 0);
      // Illegal cpu 3: accepted, dropped, err pulses once.
      add(1, 1, 3, 1, 7, 7, 0,   3, 0, 2, 0, 0, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0,   3, 0, 2, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   3, 0, 2, 0, 0, 0, 1, 0, 0);
      // Write {cpu 2, addr 3, data 4}; done coincident with phase TMO-1.
      add(1, 1, 2, 1, 3, 4, 0,   3, 0, 2, 0, 0, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   2, 1, 3, 4, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   2, 1, 3, 4, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   2, 1, 3, 4, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,   2, 1, 3, 4, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,   3, 1, 3, 4, 0, 0, 1, 0, 0);
      // done in GAP and IDLE is ignored.
      add(1, 0, 0, 0, 0, 0, 1,   3, 1, 3, 4, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,   3, 1, 3, 4, 0, 0, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         resetn = vecs[i].rn;
         done   = vecs[i].dn;
         drive(vecs[i].v, vecs[i].cpu, vecs[i].rw, vecs[i].a, vecs[i].d);
         step();
         chk($sformatf("vec%0d", i), {15'd0, obs()}, {15'd0, vecs[i].exp});
      end
      done = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 3'd0, 3'd0);

      // ---------- fill queue while a transaction runs ----------
      mon_en = 1'b1;
      drive(1'b1, 2'd0, 1'b1, 3'd1, 3'd1);
      exp_q.push_back({2'd0, 1'b1, 3'd1, 3'd1});
      step();
      drive(1'b0, 2'd0, 1'b0, 3'd0, 3'd0);
      step();
      chk("fill_first_running", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] c;
         logic [2:0] v3;
         c  = 2'(i % 3);
         v3 = 3'(i + 2);
         drive(1'b1, c, i[0], v3, 3'(7 - i));
         exp_q.push_back({c, i[0], v3, 3'(7 - i)});
         step();
      end
      chk("full_count", {28'd0, count}, 32'd4);
      chk("full_ready", {31'd0, in_ready}, 32'd0);

      // Fifth push waits until the first pop frees a slot.
      drive(1'b1, 2'd2, 1'b0, 3'd6, 3'd5);
      begin
         int w;
         w = 0;
         while (!in_ready && w < 20) begin
            step();
            w++;
         end
         chk("ready_recover", {31'd0, in_ready}, 32'd1);
         chk("recover_count", {28'd0, count}, 32'd3);
      end
      exp_q.push_back({2'd2, 1'b0, 3'd6, 3'd5});
      step();
      drive(1'b0, 2'd0, 1'b0, 3'd0, 3'd0);
      done = 1'b1;
      begin
         int w;
         w = 0;
         while ((exp_q.size() != 0 || busy) && w < 200) begin
            step();
            w++;
         end
         chk("drain_bound", {31'd0, (w < 200)}, 32'd1);
      end
      done = 1'b0;
      step();
      chk("drain_count", {28'd0, count}, 32'd0);

      // ---------- reset mid-RUN with 2 entries queued ----------
      drive(1'b1, 2'd1, 1'b1, 3'd4, 3'd3);
      exp_q.push_back({2'd1, 1'b1, 3'd4, 3'd3});
      step();
      drive(1'b0, 2'd0, 1'b0, 3'd0, 3'd0);
      step();
      drive(1'b1, 2'd0, 1'b0, 3'd5, 3'd0);
      step();
      drive(1'b1, 2'd2, 1'b1, 3'd6, 3'd1);
      step();
      chk("pre_reset_count", {28'd0, count}, 32'd2);
      chk("pre_reset_busy", {31'd0, busy}, 32'd1);
      drive(1'b0, 2'd0, 1'b0, 3'd0, 3'd0);
      resetn = 1'b0;
      step();
      chk("rst_run", {26'd0, execpu, count, busy, timeout},
          {26'd0, 2'b11, 4'd0, 1'b0, 1'b0});
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (timeout) chk("rst_no_timeout", {31'd0, timeout}, 32'd0);
      end
      chk("rst_no_issue", {26'd0, execpu, count}, {26'd0, 2'b11, 4'd0});
      chk("rst_exp_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
